cell_particle_fetch: RTL and testbench
======================================

CELL_PARTICLE_FETCH -- requirements
Module: cell_particle_fetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 96, meaning packed particle position {posz, posy, posx}, 32 bits each.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning cell memory address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning output skid FIFO entries; must be a power of 2 and at least 4.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 start  in  1  one-cycle request to stream the current cell; honoured only in IDLE.
REQ-008 mem_address  out  ADDR_WIDTH  read address to the cell memory.
REQ-009 mem_rden  out  1  read enable to the cell memory.
REQ-010 mem_wren  out  1  tied 0.
REQ-011 mem_q  in  DATA_WIDTH  cell memory read data, valid 2 cycles after the cycle in which mem_rden=1.
REQ-012 out_data  out  DATA_WIDTH  particle position.
REQ-013 out_pid  out  ADDR_WIDTH  particle index, 1..count.
REQ-014 out_valid  out  1  out_data, out_pid and out_last are valid.
REQ-015 out_ready  in  1  consumer accepts the beat; transfer occurs when out_valid and out_ready are both 1.
REQ-016 out_last  out  1  the current beat is the final particle of the cell.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse after the last beat transfers, or after a zero-count cell.

Function
REQ-019 The FSM SHALL have the states IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN and FINISH.
REQ-020 IDLE -> RD_CNT on start; RD_CNT drives mem_address=0 and mem_rden=1 for 1 cycle, then enters WAIT_CNT.
REQ-021 WAIT_CNT SHALL wait 2 cycles, then latch count = mem_q[ADDR_WIDTH-1:0].
REQ-022 On leaving WAIT_CNT, count=0 -> FINISH, otherwise -> STREAM.
REQ-023 In STREAM, mem_rden=1 with mem_address=next_addr (starting at 1) only when in-flight reads plus FIFO occupancy < FIFO_DEPTH.
REQ-024 next_addr SHALL increment on each issued read; STREAM -> DRAIN in the cycle the read of address count is issued.
REQ-025 A 2-stage valid shift register SHALL track in-flight reads; each mem_q return SHALL be pushed into the FIFO tagged with its pid and last = (pid == count).
REQ-026 The FIFO SHALL never overflow.
REQ-027 Returned data SHALL never be dropped regardless of out_ready.
REQ-028 out_valid = FIFO not empty; outputs are driven from the FIFO head (first-word-fall-through).
REQ-029 Simultaneous push and pop SHALL keep occupancy unchanged.
REQ-030 Read addresses SHALL be issued and output beats delivered in strictly ascending pid order.
REQ-031 DRAIN -> FINISH when the beat with out_last transfers.
REQ-032 FINISH asserts done for 1 cycle -> IDLE.
REQ-033 start in any state other than IDLE SHALL be ignored.
REQ-034 With out_ready held at 1, the sustained rate SHALL be 1 beat/cycle.
REQ-035 First-beat latency with out_ready=1: start at cycle 0; count read in cycle 1; count latched in cycle 3; first read in cycle 4; first out_valid in cycle 6.
REQ-036 A count of 2^ADDR_WIDTH-1 SHALL stream correctly without address wrap, and next_addr SHALL never wrap.

Reset
REQ-037 rst asserted SHALL force the following immediately: state=IDLE, FIFO empty, in-flight=0, count=0, next_addr=0.
REQ-038 rst asserted SHALL force the following outputs to 0 immediately: mem_address, mem_rden, out_valid, out_last, out_data, out_pid, busy, done.
REQ-039 rst mid-stream SHALL abandon the cell; returns arriving after reset release SHALL be ignored; done SHALL not pulse.

Structure
REQ-040 The 2-cycle memory read latency, the state encodings and the count address (0) SHALL be constants in the shared define file.
REQ-041 The FIFO SHALL be a sub-module named particle_skid_fifo, with parameterised width and depth and full/empty/count outputs.

Verification
REQ-042 count=5, out_ready=1 -> pids 1..5 on consecutive cycles 6..10, out_last at pid 5, done in cycle 11.
REQ-043 count=0 -> no out_valid, done pulses once, and mem_rden is never asserted beyond address 0.
REQ-044 count=8 with out_ready toggling 1010 -> all 8 beats delivered in order, and the FIFO occupancy counter never exceeds 4.
REQ-045 count=8 with out_ready held at 0 for 20 cycles -> exactly 4 reads issued, out_valid held with pid 1, and the stream completes after out_ready=1.
REQ-046 rst asserted at the third beat of count=10 -> all outputs 0 that cycle; after release, start with count=3 yields pids 1..3 only.
REQ-047 start pulsed during STREAM -> no effect, and exactly one done pulse.

Source files
------------

// File: rtl/cell_particle_fetch_pkg.sv
// Shared constants and state encoding for the cell particle fetch engine.
package cell_particle_fetch_pkg;

    localparam int MEM_RD_LATENCY = 2;
    localparam int COUNT_ADDR     = 0;
    localparam int WAIT_W         = $clog2(MEM_RD_LATENCY) + 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_CNT   = 3'd1,
        ST_WAIT_CNT = 3'd2,
        ST_STREAM   = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_FINISH   = 3'd5
    } fetch_state_e;

endpackage

// File: rtl/particle_skid_fifo.sv
// First-word-fall-through skid FIFO; a push into an empty FIFO is visible on
// rd_data in the same cycle and is not stored if it is popped immediately.
module particle_skid_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_store, do_take;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;

    // Empty FIFO outputs zero unless the incoming word bypasses storage.
    assign rd_data = !empty ? store_q[rd_ptr_q] : (push ? wr_data : '0);

    always_comb begin
        do_store = push && !(empty && pop);
        do_take  = pop && !empty;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_store);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_take);
        count_d  = count_q + CNT_W'(do_store) - CNT_W'(do_take);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_store) begin
            store_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/cell_particle_fetch.sv
// Reads a cell's particle count from address 0, then streams particles 1..count
// through a skid FIFO with reads throttled so returned data is never dropped.
module cell_particle_fetch
    import cell_particle_fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 96,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_pid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int OCC_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;

    fetch_state_e                state_q, state_d;
    logic [WAIT_W-1:0]           wait_q, wait_d;
    logic [ADDR_WIDTH-1:0]       count_q, count_d;
    logic [ADDR_WIDTH:0]         next_addr_q, next_addr_d;
    logic [MEM_RD_LATENCY-1:0]   rd_vld_q, rd_vld_d;
    logic [ADDR_WIDTH-1:0]       rd_pid_q [MEM_RD_LATENCY];
    logic [ADDR_WIDTH-1:0]       rd_pid_d [MEM_RD_LATENCY];

    logic                        issue;
    logic [OCC_W:0]              pending;
    logic                        ret_valid;
    logic [ADDR_WIDTH-1:0]       ret_pid;
    logic [ENTRY_W-1:0]          ret_entry, head_entry;
    logic                        fifo_full, fifo_empty, pop;
    logic [OCC_W-1:0]            fifo_count;

    assign mem_wren  = 1'b0;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FINISH);

    assign ret_valid = rd_vld_q[MEM_RD_LATENCY-1];
    assign ret_pid   = rd_pid_q[MEM_RD_LATENCY-1];
    assign ret_entry = {(ret_pid == count_q), ret_pid, mem_q};
    assign out_valid = !fifo_empty || ret_valid;
    assign pop       = out_valid && out_ready;
    assign {out_last, out_pid, out_data} = head_entry;

    // Every read still in flight already owns a FIFO slot.
    assign pending = (OCC_W+1)'(fifo_count) + (OCC_W+1)'($countones(rd_vld_q));

    // NOTE: every signal gets a default first so no branch can infer a latch.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        count_d     = count_q;
        next_addr_d = next_addr_q;
        mem_rden    = 1'b0;
        mem_address = '0;
        issue       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RD_CNT;
            end
            ST_RD_CNT: begin
                mem_rden    = 1'b1;
                mem_address = ADDR_WIDTH'(COUNT_ADDR);
                wait_d      = '0;
                state_d     = ST_WAIT_CNT;
            end
            ST_WAIT_CNT: begin
                if (wait_q == WAIT_W'(MEM_RD_LATENCY - 1)) begin
                    count_d     = mem_q[ADDR_WIDTH-1:0];
                    next_addr_d = (ADDR_WIDTH+1)'(1);
                    state_d     = (mem_q[ADDR_WIDTH-1:0] == '0) ? ST_FINISH : ST_STREAM;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_STREAM: begin
                if (!fifo_full && pending < (OCC_W+1)'(FIFO_DEPTH)) begin
                    issue       = 1'b1;
                    mem_rden    = 1'b1;
                    mem_address = next_addr_q[ADDR_WIDTH-1:0];
                    next_addr_d = next_addr_q + (ADDR_WIDTH+1)'(1);
                    if (next_addr_q == {1'b0, count_q}) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && out_last) state_d = ST_FINISH;
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rd_vld_d[0] = issue;
        rd_pid_d[0] = next_addr_q[ADDR_WIDTH-1:0];
        for (int i = 1; i < MEM_RD_LATENCY; i++) begin
            rd_vld_d[i] = rd_vld_q[i-1];
            rd_pid_d[i] = rd_pid_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            count_q     <= '0;
            next_addr_q <= '0;
            rd_vld_q    <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            count_q     <= count_d;
            next_addr_q <= next_addr_d;
            rd_vld_q    <= rd_vld_d;
        end
    end

    // Tags only matter alongside rd_vld_q, which is reset.
    always_ff @(posedge clk) begin
        rd_pid_q <= rd_pid_d;
    end

    particle_skid_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (ret_valid),
        .wr_data (ret_entry),
        .pop     (pop),
        .rd_data (head_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_cell_particle_fetch.sv
// Directed bench for cell_particle_fetch with a 2-cycle-latency cell memory model.
module tb_cell_particle_fetch;

    localparam int DW    = 96;
    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] mem_address;
    logic          mem_rden;
    logic          mem_wren;
    logic [DW-1:0] mem_q;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_pid;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;

    int vectors = 0;
    int errors  = 0;

    cell_particle_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mem_address (mem_address),
        .mem_rden    (mem_rden),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q),
        .out_data    (out_data),
        .out_pid     (out_pid),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Cell memory: data appears two cycles after the cycle with mem_rden=1.
    logic [DW-1:0] cell_mem [256];
    logic [DW-1:0] p1_data;
    logic          p1_vld;
    always @(posedge clk) begin
        p1_vld  <= mem_rden;
        p1_data <= cell_mem[mem_address];
        mem_q   <= p1_vld ? p1_data : {3{32'hDEAD_BEEF}};
    end

    function automatic logic [DW-1:0] pos_of(input int pid);
        return {32'hC000_0000 | 32'(pid), 32'hB000_0000 | 32'(pid), 32'hA000_0000 | 32'(pid)};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          start;
        logic          rden;
        logic [AW-1:0] addr;
        logic          valid;
        logic [AW-1:0] pid;
        logic          last;
        logic          busy;
        logic          done;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic rd, input int a, input logic v,
                                input int p, input logic l, input logic b, input logic d);
        vec_t r;
        r.start = s; r.rden = rd; r.addr = AW'(a); r.valid = v;
        r.pid = AW'(p); r.last = l; r.busy = b; r.done = d;
        return r;
    endfunction

    // Streams one cell from start; mode 0: ready=1, 1: ready toggles 1010, 2: ready=0 until cycle hold.
    task automatic run_cell(input int cnt, input int mode, input int hold, input int restart_at, input string tag);
        int reads = 0, addr_err = 0, beats = 0, beat_err = 0, done_n = 0, done_cyc = 0, max_occ = 0;
        int budget;
        bit finished = 0;
        budget = 4 * cnt + hold + 60;
        cell_mem[0] = DW'(cnt);
        for (int cyc = 0; cyc < budget && !finished; cyc++) begin
            next_cycle();
            start = (cyc == 0) || (cyc == restart_at);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = (cyc >= hold);
            endcase
            #2;
            if (mem_rden) begin
                if (int'(mem_address) != reads) addr_err++;
                reads++;
            end
            if (out_valid && out_ready) begin
                if (int'(out_pid) != beats + 1 || out_data !== pos_of(beats + 1) ||
                    out_last !== (beats + 1 == cnt)) beat_err++;
                beats++;
            end
            if (int'(dut.fifo_count) > max_occ) max_occ = int'(dut.fifo_count);
            if (mode == 2 && cyc == hold - 1) begin
                check({tag, ".held_reads"}, reads, 1 + DEPTH);
                check({tag, ".held_head"}, {out_valid, out_pid}, {1'b1, AW'(1)});
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (done_n > 0 && cyc >= done_cyc + 3) finished = 1;
        end
        check({tag, ".completed"}, finished, 1);
        check({tag, ".beats"}, beats, cnt);
        check({tag, ".beat_order"}, beat_err, 0);
        check({tag, ".reads"}, reads, cnt + 1);
        check({tag, ".read_order"}, addr_err, 0);
        check({tag, ".done_pulses"}, done_n, 1);
        check({tag, ".occ_over_depth"}, max_occ > DEPTH, 0);
        check({tag, ".idle_after"}, {busy, out_valid}, 0);
    endtask

    vec_t vt [13];

    initial begin
        int   stray;
        bit   found;

        vt[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
        vt[1]  = mk(0, 1, 0, 0, 0, 0, 1, 0);
        vt[2]  = mk(0, 0, 0, 0, 0, 0, 1, 0);
        vt[3]  = mk(0, 0, 0, 0, 0, 0, 1, 0);
        vt[4]  = mk(0, 1, 1, 0, 0, 0, 1, 0);
        vt[5]  = mk(0, 1, 2, 0, 0, 0, 1, 0);
        vt[6]  = mk(0, 1, 3, 1, 1, 0, 1, 0);
        vt[7]  = mk(0, 1, 4, 1, 2, 0, 1, 0);
        vt[8]  = mk(0, 1, 5, 1, 3, 0, 1, 0);
        vt[9]  = mk(0, 0, 0, 1, 4, 0, 1, 0);
        vt[10] = mk(0, 0, 0, 1, 5, 1, 1, 0);
        vt[11] = mk(0, 0, 0, 0, 0, 0, 1, 1);
        vt[12] = mk(0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 1; i < 256; i++) cell_mem[i] = pos_of(i);
        cell_mem[0] = '0;

        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.outputs", {out_valid, out_last, out_data, out_pid, mem_rden, mem_address, busy, done, mem_wren}, '0);
        rst = 1'b0;

        // count=5, ready=1: cycle-exact table
        cell_mem[0] = DW'(5);
        for (int c = 0; c < 13; c++) begin
            next_cycle();
            start = vt[c].start;
            out_ready = 1'b1;
            #2;
            check($sformatf("basic5.cyc%0d", c),
                  {mem_rden, mem_rden ? mem_address : AW'(0), out_valid, out_valid ? out_pid : AW'(0), out_last, busy, done},
                  {vt[c].rden, vt[c].addr, vt[c].valid, vt[c].pid, vt[c].last, vt[c].busy, vt[c].done});
            if (vt[c].valid) check($sformatf("basic5.data%0d", c), out_data, pos_of(int'(vt[c].pid)));
        end

        run_cell(0, 0, 0, -1, "zero");
        run_cell(8, 1, 0, -1, "toggle8");
        run_cell(8, 2, 20, -1, "hold8");
        run_cell(5, 0, 0, 5, "restart5");

        // Reset at the third beat of a count=10 cell, released while reads are in flight.
        cell_mem[0] = DW'(10);
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            next_cycle();
            start = (c == 0);
            out_ready = 1'b1;
            #2;
            if (out_valid && out_pid == AW'(3)) found = 1;
        end
        check("rst10.third_beat_seen", found, 1);
        rst = 1'b1;
        #1;
        check("rst10.outputs_zero", {out_valid, out_last, out_data, out_pid, mem_rden, mem_address, busy, done}, '0);
        next_cycle();
        rst = 1'b0;
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            #2;
            if (out_valid || done || busy || mem_rden) stray++;
            next_cycle();
        end
        check("rst10.quiet_after_release", stray, 0);
        run_cell(3, 0, 0, -1, "post_rst3");

        run_cell(255, 0, 0, -1, "max255");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
